// File: rtl/dp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : dp_pkg                                                           |
// | Shared types for the accumulator datapath: transfer command codes, ALU     |
// | operations, jump conditions, memory FSM states and flag bit positions.     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package dp_pkg;

  typedef enum logic [3:0] {
    XFER_NOP    = 4'h0,  // no transfer
    XFER_MA_PC  = 4'h1,  // MA <= PC
    XFER_MEM_RD = 4'h2,  // start memory read into MD
    XFER_IR_MD  = 4'h3,  // IR <= MD
    XFER_MA_MD  = 4'h4,  // MA <= MD
    XFER_ACC_MD = 4'h5,  // A|AP <= MD
    XFER_MA_AP  = 4'h6,  // MA <= AP
    XFER_MA_SP  = 4'h7,  // MA <= SP
    XFER_MD_ACC = 4'h8,  // MD <= A|AP
    XFER_MEM_WR = 4'h9,  // start memory write of MD
    XFER_ACC_R  = 4'hA,  // A|AP <= R
    XFER_JMP    = 4'hB,  // PC <= MD if condition holds
    XFER_A_IN   = 4'hC,  // A <= IN
    XFER_OUT_A  = 4'hD,  // OUT <= A
    XFER_PC_AP  = 4'hE,  // PC <= AP
    XFER_MD_PC  = 4'hF   // MD <= PC, zero-extended
  } xfer_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_NOT = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4,
    ALU_XOR = 3'd5,
    ALU_SHR = 3'd6
  } alu_op_e;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'd0,
    COND_Z      = 2'd1,
    COND_C      = 2'd2,
    COND_N      = 2'd3
  } cond_e;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  // Bit positions inside the {N, C, Z} flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

endpackage
`default_nettype wire

// File: rtl/dp_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dp_alu                                                           |
// | Combinational ALU of the accumulator datapath. The result is formed at     |
// | DATA_W+1 bits so ADD carry-out and SUB borrow fall out of the top bit.     |
// | Ports   : op  - operation select (alu_op_e)                                |
// |           x   - selected accumulator (A or AP), used by ADD/SUB            |
// |           md  - memory data register, second operand                       |
// |           a   - accumulator A, operand of the logic ops and SHR            |
// |           res - DATA_W-bit result; c, z, n - carry/zero/negative           |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module dp_alu
  import dp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_e             op,
  input  logic [DATA_W-1:0]   x,
  input  logic [DATA_W-1:0]   md,
  input  logic [DATA_W-1:0]   a,
  output logic [DATA_W-1:0]   res,
  output logic                c,
  output logic                z,
  output logic                n
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    c    = 1'b0;
    case (op)
      ALU_ADD: begin
        wide = {1'b0, x} + {1'b0, md};
        c    = wide[DATA_W];
      end
      ALU_SUB: begin
        // Top bit of the extended difference is set exactly when x < md
        wide = {1'b0, x} - {1'b0, md};
        c    = wide[DATA_W];
      end
      ALU_NOT: wide = {1'b0, ~a};
      ALU_OR:  wide = {1'b0, a | md};
      ALU_AND: wide = {1'b0, a & md};
      ALU_XOR: wide = {1'b0, a ^ md};
      ALU_SHR: begin
        wide = {2'b00, a[DATA_W-1:1]};
        c    = a[0];
      end
      default: wide = '0;
    endcase
  end

  assign res = wide[DATA_W-1:0];
  assign z   = (res == '0);
  assign n   = res[DATA_W-1];

endmodule
`default_nettype wire

// File: rtl/data_path_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : data_path_gen                                                    |
// | Accumulator datapath between the control FSM and memory/IO: PC, IR, MA,    |
// | MD, A, AP, R, IN, OUT, SP and {N,C,Z} flags, with a req/ack memory FSM.    |
// | Optional feature macro: DATA_PATH_SP_GUARD_EN (stack overflow/underflow    |
// | guard with sticky o_sp_fault; without it SP wraps and o_sp_fault is 0).    |
// | Ports   : i_clk, i_rst (sync, active-high)                                 |
// |           i_transfer_cmd, i_alu_op, i_alu_calculate, i_alu_dst_ap, i_cond, |
// |           i_inc_pc, i_inc_dec_sp, i_reset_ir - control from the sequencer  |
// |           i_in - input port; i_mem_rdata/i_mem_ack - memory response       |
// |           o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata - memory request       |
// |           o_busy - memory FSM active; o_out, o_ir, o_flags, o_sp_fault     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module data_path_gen
  import dp_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter int                ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'('h7F),
  parameter logic [ADDR_W-1:0] SP_MIN  = ADDR_W'('h00)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_transfer_cmd,
  input  logic [2:0]        i_alu_op,
  input  logic              i_alu_calculate,
  input  logic              i_alu_dst_ap,
  input  logic [1:0]        i_cond,
  input  logic              i_inc_pc,
  input  logic [1:0]        i_inc_dec_sp,
  input  logic              i_reset_ir,
  input  logic [DATA_W-1:0] i_in,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_out,
  output logic [DATA_W-1:0] o_ir,
  output logic [2:0]        o_flags,
  output logic              o_sp_fault
);

  logic [ADDR_W-1:0] pc_q, pc_d, ma_q, ma_d, sp_q, sp_d;
  logic [DATA_W-1:0] ir_q, ir_d, md_q, md_d, a_q, a_d, ap_q, ap_d;
  logic [DATA_W-1:0] r_q, r_d, out_q, out_d, in_q;
  logic [2:0]        flags_q, flags_d;
  logic              sp_fault_q, sp_fault_d;

  mem_state_e        state_q;
  logic              mem_req_q, mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              busy;
  xfer_e             cmd;
  logic [DATA_W-1:0] opnd;
  logic              cond_ok;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_z, alu_n;
  logic              sp_inc, sp_dec;

  assign busy   = (state_q == MEM_WAIT);
  // A stalled controller may still present a command; drop it while busy
  assign cmd    = busy ? XFER_NOP : xfer_e'(i_transfer_cmd);
  assign opnd   = i_alu_dst_ap ? ap_q : a_q;
  assign sp_inc = (i_inc_dec_sp == 2'b01);
  assign sp_dec = (i_inc_dec_sp == 2'b10);

  dp_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op  (alu_op_e'(i_alu_op)),
    .x   (opnd),
    .md  (md_q),
    .a   (a_q),
    .res (alu_res),
    .c   (alu_c),
    .z   (alu_z),
    .n   (alu_n)
  );

  // Jump condition evaluated on flags registered before this edge
  always_comb begin
    cond_ok = 1'b1;
    case (cond_e'(i_cond))
      COND_ALWAYS: cond_ok = 1'b1;
      COND_Z:      cond_ok = flags_q[FLAG_Z];
      COND_C:      cond_ok = flags_q[FLAG_C];
      COND_N:      cond_ok = flags_q[FLAG_N];
      default:     cond_ok = 1'b1;
    endcase
  end

  always_comb begin
    pc_d       = i_inc_pc ? pc_q + ADDR_W'(1) : pc_q;
    ir_d       = ir_q;
    ma_d       = ma_q;
    md_d       = md_q;
    a_d        = a_q;
    ap_d       = ap_q;
    r_d        = r_q;
    out_d      = out_q;
    flags_d    = flags_q;
    sp_d       = sp_q;
    sp_fault_d = sp_fault_q;

    // Register transfers; PC writes here override the increment above
    case (cmd)
      XFER_MA_PC:  ma_d = pc_q;
      XFER_IR_MD:  ir_d = md_q;
      XFER_MA_MD:  ma_d = md_q[ADDR_W-1:0];
      XFER_ACC_MD: if (i_alu_dst_ap) ap_d = md_q; else a_d = md_q;
      XFER_MA_AP:  ma_d = ADDR_W'(ap_q);
      XFER_MA_SP:  ma_d = sp_q;
      XFER_MD_ACC: md_d = opnd;
      XFER_ACC_R:  if (i_alu_dst_ap) ap_d = r_q; else a_d = r_q;
      XFER_JMP:    if (cond_ok) pc_d = md_q[ADDR_W-1:0];
      XFER_A_IN:   a_d = in_q;
      XFER_OUT_A:  out_d = a_q;
      XFER_PC_AP:  pc_d = ADDR_W'(ap_q);
      XFER_MD_PC:  md_d = DATA_W'(pc_q);
      default:     ;
    endcase

    if (i_reset_ir) ir_d = '0;

    // Read completion; cannot collide with an MD transfer since cmd is NOP in WAIT
    if (busy && i_mem_ack && !mem_we_q) md_d = i_mem_rdata;

    if (i_alu_calculate) begin
      r_d             = alu_res;
      flags_d[FLAG_Z] = alu_z;
      flags_d[FLAG_C] = alu_c;
      flags_d[FLAG_N] = alu_n;
    end

`ifdef DATA_PATH_SP_GUARD_EN
    if (sp_inc) begin
      if (sp_q == SP_INIT) sp_fault_d = 1'b1;
      else                 sp_d = sp_q + ADDR_W'(1);
    end else if (sp_dec) begin
      if (sp_q == SP_MIN)  sp_fault_d = 1'b1;
      else                 sp_d = sp_q - ADDR_W'(1);
    end
`else
    sp_fault_d = 1'b0;
    if (sp_inc)      sp_d = sp_q + ADDR_W'(1);
    else if (sp_dec) sp_d = sp_q - ADDR_W'(1);
`endif
  end

`ifndef DATA_PATH_SP_GUARD_EN
  logic unused_sp_min;
  assign unused_sp_min = ^SP_MIN;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q       <= '0;
      ir_q       <= '0;
      ma_q       <= '0;
      md_q       <= '0;
      a_q        <= '0;
      ap_q       <= '0;
      r_q        <= '0;
      in_q       <= '0;
      out_q      <= '0;
      sp_q       <= SP_INIT;
      flags_q    <= '0;
      sp_fault_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ma_q       <= ma_d;
      md_q       <= md_d;
      a_q        <= a_d;
      ap_q       <= ap_d;
      r_q        <= r_d;
      in_q       <= i_in;
      out_q      <= out_d;
      sp_q       <= sp_d;
      flags_q    <= flags_d;
      sp_fault_q <= sp_fault_d;
    end
  end

  // Memory handshake FSM; request signals are registered and held in WAIT
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= MEM_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (cmd == XFER_MEM_RD) begin
            state_q     <= MEM_WAIT;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
          end else if (cmd == XFER_MEM_WR) begin
            state_q     <= MEM_WAIT;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= md_q;
          end
        end
        MEM_WAIT: begin
          if (i_mem_ack) begin
            state_q     <= MEM_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
          end
        end
        default: begin
          state_q   <= MEM_IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = ma_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_busy      = busy;
  assign o_out       = out_q;
  assign o_ir        = ir_q;
  assign o_flags     = flags_q;
  assign o_sp_fault  = sp_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_data_path_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_data_path_gen                                                 |
// | Self-checking bench for data_path_gen (default parameters). A behavioural  |
// | register-level model predicts every output each cycle; directed sequences  |
// | add hand-computed literal checks. DATA_PATH_SP_GUARD_EN selects the stack  |
// | expectations.                                                              |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_data_path_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cmd;
  logic [2:0] alu_op;
  logic       calc, dst_ap, inc_pc, reset_ir, ack;
  logic [1:0] cond, incdec;
  logic [7:0] in_v, rdata;

  logic       mem_req, mem_we, busy, sp_fault;
  logic [7:0] mem_addr, mem_wdata, out_v, ir_v;
  logic [2:0] flags;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  data_path_gen dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_transfer_cmd  (cmd),
    .i_alu_op        (alu_op),
    .i_alu_calculate (calc),
    .i_alu_dst_ap    (dst_ap),
    .i_cond          (cond),
    .i_inc_pc        (inc_pc),
    .i_inc_dec_sp    (incdec),
    .i_reset_ir      (reset_ir),
    .i_in            (in_v),
    .i_mem_rdata     (rdata),
    .i_mem_ack       (ack),
    .o_mem_req       (mem_req),
    .o_mem_we        (mem_we),
    .o_mem_addr      (mem_addr),
    .o_mem_wdata     (mem_wdata),
    .o_busy          (busy),
    .o_out           (out_v),
    .o_ir            (ir_v),
    .o_flags         (flags),
    .o_sp_fault      (sp_fault)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_pc, m_ir, m_ma, m_md, m_a, m_ap, m_r, m_in, m_out, m_sp, m_wd;
  logic       m_n, m_c, m_z, m_fault, m_wait, m_we;
  logic [7:0] t_pc, t_ir, t_ma, t_md, t_a, t_ap, t_r, t_out, t_sp, t_wd, t_x;
  logic       t_n, t_c, t_z, t_fault, t_wait, t_we, t_take;
  int         k, s;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_ir = 0; m_ma = 0; m_md = 0; m_a = 0; m_ap = 0; m_r = 0;
      m_in = 0; m_out = 0; m_sp = 8'h7F; m_wd = 0;
      m_n = 0; m_c = 0; m_z = 0; m_fault = 0; m_wait = 0; m_we = 0;
    end else begin
      k = m_wait ? 0 : int'(cmd);
      t_x = dst_ap ? m_ap : m_a;
      t_pc = m_pc; t_ir = m_ir; t_ma = m_ma; t_md = m_md; t_a = m_a; t_ap = m_ap;
      t_r = m_r; t_out = m_out; t_sp = m_sp; t_wd = m_wd;
      t_n = m_n; t_c = m_c; t_z = m_z; t_fault = m_fault; t_wait = m_wait; t_we = m_we;

      if (m_wait) begin
        if (ack) begin
          if (!m_we) t_md = rdata;
          t_wait = 0; t_we = 0; t_wd = 0;
        end
      end else if (k == 2) begin
        t_wait = 1; t_we = 0; t_wd = 0;
      end else if (k == 9) begin
        t_wait = 1; t_we = 1; t_wd = m_md;
      end

      case (k)
        1:  t_ma = m_pc;
        3:  t_ir = m_md;
        4:  t_ma = m_md;
        5:  if (dst_ap) t_ap = m_md; else t_a = m_md;
        6:  t_ma = m_ap;
        7:  t_ma = m_sp;
        8:  t_md = t_x;
        10: if (dst_ap) t_ap = m_r; else t_a = m_r;
        12: t_a = m_in;
        13: t_out = m_a;
        15: t_md = m_pc;
        default: ;
      endcase

      t_take = (cond == 0) || (cond == 1 && m_z) || (cond == 2 && m_c) || (cond == 3 && m_n);
      if (k == 11 && t_take) t_pc = m_md;
      else if (k == 14)      t_pc = m_ap;
      else if (inc_pc)       t_pc = m_pc + 8'd1;

      if (reset_ir) t_ir = 0;

      if (calc) begin
        t_c = 0;
        case (alu_op)
          3'd0: begin s = int'(t_x) + int'(m_md); t_c = (s > 255); end
          3'd1: begin s = int'(t_x) - int'(m_md); t_c = (s < 0); end
          3'd2: s = 255 - int'(m_a);
          3'd3: s = int'(m_a | m_md);
          3'd4: s = int'(m_a & m_md);
          3'd5: s = int'(m_a ^ m_md);
          3'd6: begin s = int'(m_a) / 2; t_c = m_a[0]; end
          default: s = 0;
        endcase
        t_r = 8'(s & 255);
        t_z = (t_r == 0);
        t_n = (t_r >= 8'd128);
      end

`ifdef DATA_PATH_SP_GUARD_EN
      if (incdec == 2'b01) begin
        if (m_sp == 8'h7F) t_fault = 1; else t_sp = m_sp + 8'd1;
      end else if (incdec == 2'b10) begin
        if (m_sp == 8'h00) t_fault = 1; else t_sp = m_sp - 8'd1;
      end
`else
      if (incdec == 2'b01)      t_sp = m_sp + 8'd1;
      else if (incdec == 2'b10) t_sp = m_sp - 8'd1;
`endif

      m_pc = t_pc; m_ir = t_ir; m_ma = t_ma; m_md = t_md; m_a = t_a; m_ap = t_ap;
      m_r = t_r; m_out = t_out; m_sp = t_sp; m_wd = t_wd; m_in = in_v;
      m_n = t_n; m_c = t_c; m_z = t_z; m_fault = t_fault; m_wait = t_wait; m_we = t_we;
    end
  end

  // Compare every output against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("req",   mem_req,   m_wait);
      check("we",    mem_we,    m_wait & m_we);
      check("addr",  mem_addr,  m_ma);
      check("wdata", mem_wdata, m_wd);
      check("busy",  busy,      m_wait);
      check("out",   out_v,     m_out);
      check("ir",    ir_v,      m_ir);
      check("flags", flags,     {m_n, m_c, m_z});
      check("fault", sp_fault,  m_fault);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    cmd = 0; calc = 0; inc_pc = 0; incdec = 0; reset_ir = 0; ack = 0;
  endtask

  task automatic do_cmd(input logic [3:0] c);
    cmd = c;
    cyc();
  endtask

  task automatic set_a(input logic [7:0] v);
    in_v = v;
    cyc();
    do_cmd(4'hC);
  endtask

  int bcnt;

  initial begin
    rst = 1; cmd = 0; alu_op = 0; calc = 0; dst_ap = 0; cond = 0; inc_pc = 0;
    incdec = 0; reset_ir = 0; in_v = 0; rdata = 0; ack = 0;
    cyc(); cyc();
    chk_en = 1;
    rst = 0;
    check("rst_flags", flags, 3'b000);
    check("rst_req", mem_req, 1'b0);
    do_cmd(4'h7);
    check("sp_init", mem_addr, 8'h7F);

    // Read handshake with three WAIT cycles; cmd 4 during busy must be dropped
    set_a(8'h10); do_cmd(4'h8); do_cmd(4'h4);
    check("ma_10", mem_addr, 8'h10);
    set_a(8'h55); do_cmd(4'h8);
    cmd = 4'h2; cyc();
    bcnt = 0;
    cmd = 4'h4;
    for (int i = 0; i < 10; i++) begin
      if (!busy) break;
      bcnt++;
      if (bcnt == 3) begin ack = 1; rdata = 8'hA5; end
      cyc();
    end
    check("busy_cycles", bcnt, 3);
    check("ma_kept", mem_addr, 8'h10);
    do_cmd(4'h4);
    check("md_read", mem_addr, 8'hA5);

    // ALU ADD FF+01 and SUB 00-01
    set_a(8'h01); do_cmd(4'h8);
    set_a(8'hFF);
    dst_ap = 0; alu_op = 3'd0; calc = 1; cyc();
    check("add_flags", flags, 3'b011);
    set_a(8'h00);
    alu_op = 3'd1; calc = 1; cyc();
    check("sub_flags", flags, 3'b110);
    do_cmd(4'hA); do_cmd(4'hD);
    check("sub_r", out_v, 8'hFF);

    // Conditional jump on Z, taken and not taken, with concurrent PC increment
    set_a(8'h40); do_cmd(4'h8);
    set_a(8'h00);
    alu_op = 3'd4; calc = 1; cyc();
    check("and_flags", flags, 3'b001);
    cond = 1; cmd = 4'hB; inc_pc = 1; cyc();
    do_cmd(4'h1);
    check("jmp_taken", mem_addr, 8'h40);
    alu_op = 3'd3; calc = 1; cyc();
    cmd = 4'hB; inc_pc = 1; cyc();
    do_cmd(4'h1);
    check("jmp_not", mem_addr, 8'h41);
    cond = 0;

    // Stack increment at SP_INIT, then MA<=SP with concurrent inc, then dec
    incdec = 2'b01; cyc();
    do_cmd(4'h7);
`ifdef DATA_PATH_SP_GUARD_EN
    check("sp_inc", mem_addr, 8'h7F);
    check("sp_fault", sp_fault, 1'b1);
`else
    check("sp_inc", mem_addr, 8'h80);
    check("sp_fault", sp_fault, 1'b0);
`endif
    cmd = 4'h7; incdec = 2'b01; cyc();
`ifdef DATA_PATH_SP_GUARD_EN
    check("sp_old", mem_addr, 8'h7F);
`else
    check("sp_old", mem_addr, 8'h80);
`endif
    incdec = 2'b10; cyc();
    do_cmd(4'h7);
`ifdef DATA_PATH_SP_GUARD_EN
    check("sp_dec", mem_addr, 8'h7E);
`else
    check("sp_dec", mem_addr, 8'h80);
`endif

    // IR load and reset_ir priority
    set_a(8'h3C); do_cmd(4'h8); do_cmd(4'h3);
    check("ir_load", ir_v, 8'h3C);
    cmd = 4'h3; reset_ir = 1; cyc();
    check("ir_clr", ir_v, 8'h00);

    // Write with ack in the first WAIT cycle
    cmd = 4'h9; cyc();
    check("wr_req", mem_req, 1'b1);
    check("wr_we", mem_we, 1'b1);
    check("wr_data", mem_wdata, 8'h3C);
    ack = 1; cyc();
    check("wr_we_end", mem_we, 1'b0);
    check("wr_req_end", mem_req, 1'b0);

    // Reset in the middle of a read; a late ack must not touch MD
    alu_op = 3'd1; calc = 1; cyc();
    cmd = 4'h2; cyc();
    cyc();
    rst = 1; cyc();
    rst = 0;
    check("rst_mid_req", mem_req, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_flags", flags, 3'b000);
    ack = 1; rdata = 8'hEE; cyc();
    do_cmd(4'h4);
    check("late_ack", mem_addr, 8'h00);
    do_cmd(4'h7);
    check("rst_sp", mem_addr, 8'h7F);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
